led_pattern_gen: RTL

Parametrised LED pattern generator for board-level status and demo outputs. It replaces the fixed single-pattern blinker with several things:
- A tick-enable prescaler on the single system clock. No derived clocks.
- Four runtime-selectable patterns.
- Runtime speed select.
- An enable/pause input.
It drives the board LED bank directly.

---
 rtl/led_pattern_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: tick-enable prescaler driving four selectable patterns
// (blink, chase, bounce, binary count) on a registered LED bank.
module led_pattern_gen #(
    parameter int unsigned LED_W   = 16,
    parameter int unsigned DIV_MAX = 149999999,
    parameter int unsigned CNT_W   = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    output logic [LED_W-1:0] led,
    output logic             tick
);

    typedef enum logic [1:0] {
        ModeBlink  = 2'd0,
        ModeChase  = 2'd1,
        ModeBounce = 2'd2,
        ModeCount  = 2'd3
    } mode_e;

    typedef enum logic {
        DirLeft  = 1'b0,
        DirRight = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0] DIV_VAL = CNT_W'(DIV_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [LED_W-1:0] r_led;
    logic             r_tick;
    mode_e            r_mode;
    dir_e             r_dir;

    logic [CNT_W-1:0] w_cnt;
    logic [LED_W-1:0] w_led;
    logic             w_tick;
    mode_e            w_mode;
    dir_e             w_dir;

    mode_e            w_mode_in;
    logic [CNT_W-1:0] w_reload;
    logic             w_onehot;
    logic [LED_W-1:0] w_init;
    logic [LED_W-1:0] w_step;
    dir_e             w_step_dir;

    assign w_mode_in = mode_e'(mode);
    assign w_reload  = DIV_VAL >> speed;
    assign w_onehot  = (r_led != '0) && ((r_led & (r_led - LED_ONE)) == '0);

    always_comb begin
        w_init = '0;
        unique case (w_mode_in)
            ModeChase,
            ModeBounce: w_init = LED_ONE;
            default:    w_init = '0;
        endcase
    end

    // Next pattern value for the currently registered mode; a corrupted
    // (non one-hot) chase/bounce pattern recovers to a single lit LED.
    always_comb begin
        w_step     = r_led;
        w_step_dir = r_dir;
        unique case (r_mode)
            ModeBlink: begin
                w_step = ~r_led;
            end
            ModeChase: begin
                if (!w_onehot) begin
                    w_step = LED_ONE;
                end else begin
                    w_step = {r_led[LED_W-2:0], r_led[LED_W-1]};
                end
            end
            ModeBounce: begin
                if (!w_onehot) begin
                    w_step = LED_ONE;
                end else if (r_dir == DirLeft && r_led[LED_W-1]) begin
                    w_step_dir = DirRight;
                    w_step     = r_led >> 1;
                end else if (r_dir == DirRight && r_led[0]) begin
                    w_step_dir = DirLeft;
                    w_step     = r_led << 1;
                end else if (r_dir == DirLeft) begin
                    w_step = r_led << 1;
                end else begin
                    w_step = r_led >> 1;
                end
            end
            ModeCount: begin
                w_step = r_led + LED_ONE;
            end
            default: begin
                w_step = r_led;
            end
        endcase
    end

    // Mode load wins over pause and over a tick due on the same edge.
    always_comb begin
        w_cnt  = r_cnt;
        w_led  = r_led;
        w_dir  = r_dir;
        w_tick = 1'b0;
        w_mode = w_mode_in;
        if (w_mode_in != r_mode) begin
            w_led = w_init;
            w_dir = DirLeft;
            w_cnt = w_reload;
        end else if (en) begin
            if (r_cnt != '0) begin
                w_cnt = r_cnt - CNT_ONE;
            end else begin
                w_cnt  = w_reload;
                w_tick = 1'b1;
                w_led  = w_step;
                w_dir  = w_step_dir;
            end
        end
    end

    // Reset load uses DIV_MAX directly, independent of speed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= DIV_VAL;
            r_led  <= '0;
            r_tick <= 1'b0;
            r_mode <= ModeBlink;
            r_dir  <= DirLeft;
        end else begin
            r_cnt  <= w_cnt;
            r_led  <= w_led;
            r_tick <= w_tick;
            r_mode <= w_mode;
            r_dir  <= w_dir;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule
